// File: rtl/cpu_pkg.sv
// Shared CPU definitions: instruction word layout and the fetch state encoding.
package cpu_pkg;
    localparam int INSTR_W   = 20;
    localparam int OPCODE_W  = 4;
    localparam int OPERAND_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } fetch_state_e;
endpackage

// File: rtl/instruction_fetch_if.sv
// Fetch-unit bus: program-memory req/ack, downstream valid/ready, and jump/halt control.
interface instruction_fetch_if
    import cpu_pkg::*;
#(
    parameter int ADDR_W = 8
);
    logic               mem_req;
    logic [ADDR_W-1:0]  mem_addr;
    logic               mem_ack;
    logic [INSTR_W-1:0] mem_rdata;
    logic               instr_valid;
    logic [INSTR_W-1:0] instr_data;
    logic               instr_ready;
    logic               jump_en;
    logic [ADDR_W-1:0]  jump_addr;
    logic               halt;
    logic [ADDR_W-1:0]  pc;

    modport master (
        output mem_req, mem_addr, instr_valid, instr_data, pc,
        input  mem_ack, mem_rdata, instr_ready, jump_en, jump_addr, halt
    );

    modport slave (
        input  mem_req, mem_addr, instr_valid, instr_data, pc,
        output mem_ack, mem_rdata, instr_ready, jump_en, jump_addr, halt
    );
endinterface

// File: rtl/fetch_pc.sv
// Program counter register: reset value, jump load (highest priority), wrapping increment.
module fetch_pc #(
    parameter int                ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic              inc,
    output logic [ADDR_W-1:0] pc
);
    always_ff @(posedge clk) begin
        if (rst)
            pc <= RESET_PC;
        else if (load)
            pc <= load_addr;
        else if (inc)
            pc <= pc + ADDR_W'(1);
    end
endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch: one memory read per instruction, word held until downstream accepts it.
module instruction_fetch
    import cpu_pkg::*;
#(
    parameter int                ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    instruction_fetch_if.master  bus
);
    fetch_state_e       state;
    logic               flush;
    logic               mem_req;
    logic [ADDR_W-1:0]  mem_addr;
    logic               instr_valid;
    logic [INSTR_W-1:0] instr_data;
    logic [ADDR_W-1:0]  pc;
    logic               pc_inc;

    // Only a word that is actually delivered advances the PC; a jump overrides it.
    assign pc_inc = (state == WAIT) && bus.mem_ack && !flush && !bus.jump_en;

    fetch_pc #(.ADDR_W(ADDR_W), .RESET_PC(RESET_PC)) u_pc (
        .clk       (clk),
        .rst       (rst),
        .load      (bus.jump_en),
        .load_addr (bus.jump_addr),
        .inc       (pc_inc),
        .pc        (pc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            flush       <= 1'b0;
            mem_req     <= 1'b0;
            mem_addr    <= '0;
            instr_valid <= 1'b0;
            instr_data  <= '0;
        end else begin
            case (state)
                // A jump in IDLE defers the request one cycle so it uses the new PC.
                IDLE: if (!bus.halt && !bus.jump_en) begin
                    mem_req  <= 1'b1;
                    mem_addr <= pc;
                    state    <= WAIT;
                end
                // Requests are never aborted: a jump marks the reply for discard.
                WAIT: if (bus.mem_ack) begin
                    mem_req <= 1'b0;
                    if (flush || bus.jump_en) begin
                        flush <= 1'b0;
                        state <= IDLE;
                    end else begin
                        instr_data  <= bus.mem_rdata;
                        instr_valid <= 1'b1;
                        state       <= HOLD;
                    end
                end else if (bus.jump_en) begin
                    flush <= 1'b1;
                end
                HOLD: if (bus.jump_en || bus.instr_ready) begin
                    instr_valid <= 1'b0;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.mem_req     = mem_req;
    assign bus.mem_addr    = mem_addr;
    assign bus.instr_valid = instr_valid;
    assign bus.instr_data  = instr_data;
    assign bus.pc          = pc;
endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: memory responder, accepted-word scoreboard, vector table, corner sequences.
module tb_instruction_fetch;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    instruction_fetch_if #(.ADDR_W(8)) bus ();

    instruction_fetch #(.ADDR_W(8), .RESET_PC(8'h10)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [19:0] mem [256];
    logic [7:0]  exp_addr[$];
    logic [19:0] exp_data[$];
    int          lat_cfg = 0;
    int          wait_cnt = 0;

    typedef struct {
        logic [7:0]  start_pc;
        logic [19:0] word;
        int          lat;
        logic [7:0]  exp_pc;
    } vec_t;
    vec_t vecs[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Program memory: ack after lat_cfg extra cycles, one-cycle ack pulse.
    always @(posedge clk) begin
        #1;
        if (bus.mem_ack) begin
            bus.mem_ack = 1'b0;
        end else if (bus.mem_req) begin
            if (wait_cnt >= lat_cfg) begin
                wait_cnt      = 0;
                bus.mem_rdata = mem[bus.mem_addr];
                bus.mem_ack   = 1'b1;
                if (exp_addr.size() == 0)
                    chk("unexpected_req", {24'h0, bus.mem_addr}, 32'hFFFF_FFFF);
                else
                    chk("req_addr", {24'h0, bus.mem_addr}, {24'h0, exp_addr.pop_front()});
            end else begin
                wait_cnt++;
            end
        end
    end

    // Scoreboard: every accepted word must be the next expected one.
    always @(negedge clk) begin
        if (!rst && bus.instr_valid && bus.instr_ready && !bus.jump_en) begin
            if (exp_data.size() == 0)
                chk("unexpected_word", {12'h0, bus.instr_data}, 32'hFFFF_FFFF);
            else
                chk("accepted_word", {12'h0, bus.instr_data}, {12'h0, exp_data.pop_front()});
        end
    end

    task automatic wait_valid();
        int n = 0;
        while (!bus.instr_valid && n < 40) begin
            tick();
            n++;
        end
        chk("valid_timeout", {31'h0, bus.instr_valid}, 32'h1);
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_data.size() != 0 || bus.instr_valid || bus.mem_req) && n < 40) begin
            tick();
            n++;
        end
        chk("drain", {29'h0, exp_data.size() == 0, !bus.instr_valid, !bus.mem_req}, 32'h7);
    endtask

    task automatic jump_idle(input logic [7:0] target);
        bus.jump_en   = 1'b1;
        bus.jump_addr = target;
        tick();
        bus.jump_en = 1'b0;
        chk("jump_pc", {24'h0, bus.pc}, {24'h0, target});
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            logic [7:0] a;
            a = 8'(i);
            mem[i] = {a[3:0], 8'hB0, a};
        end
        mem[8'h10] = 20'h3_0005;
        mem[8'h30] = 20'hA_1234;
        vecs[0] = '{8'h20, 20'h1_ABCD, 0, 8'h21};
        vecs[1] = '{8'h7F, 20'h5_5AA5, 1, 8'h80};
        vecs[2] = '{8'h01, 20'h0_0000, 2, 8'h02};
        vecs[3] = '{8'h9C, 20'hC_0FF0, 4, 8'h9D};
        vecs[4] = '{8'hFF, 20'hF_FFFF, 0, 8'h00};

        bus.mem_ack     = 1'b0;
        bus.mem_rdata   = '0;
        bus.instr_ready = 1'b0;
        bus.jump_en     = 1'b0;
        bus.jump_addr   = '0;
        bus.halt        = 1'b0;
        rst             = 1'b1;
        repeat (3) tick();
        chk("rst_mem_req", {31'h0, bus.mem_req}, 32'h0);
        chk("rst_mem_addr", {24'h0, bus.mem_addr}, 32'h0);
        chk("rst_valid", {31'h0, bus.instr_valid}, 32'h0);
        chk("rst_data", {12'h0, bus.instr_data}, 32'h0);
        chk("rst_pc", {24'h0, bus.pc}, 32'h10);

        // First fetch after reset, then a 5-cycle downstream stall.
        exp_addr.push_back(8'h10); exp_data.push_back(20'h3_0005);
        exp_addr.push_back(8'h11); exp_data.push_back(mem[8'h11]);
        rst = 1'b0;
        tick();
        chk("first_req", {31'h0, bus.mem_req}, 32'h1);
        chk("first_addr", {24'h0, bus.mem_addr}, 32'h10);
        wait_valid();
        chk("first_data", {12'h0, bus.instr_data}, 32'h3_0005);
        chk("first_pc", {24'h0, bus.pc}, 32'h11);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_valid", {31'h0, bus.instr_valid}, 32'h1);
            chk("stall_data", {12'h0, bus.instr_data}, 32'h3_0005);
            chk("stall_req", {31'h0, bus.mem_req}, 32'h0);
        end
        bus.instr_ready = 1'b1;
        tick();
        chk("accept_valid", {31'h0, bus.instr_valid}, 32'h0);
        chk("accept_data_kept", {12'h0, bus.instr_data}, 32'h3_0005);
        tick();
        chk("next_req", {31'h0, bus.mem_req}, 32'h1);
        chk("next_addr", {24'h0, bus.mem_addr}, 32'h11);
        bus.halt = 1'b1;
        drain();

        // Vector table: halt is raised while WAIT, so each fetch still completes then parks.
        foreach (vecs[k]) begin
            lat_cfg = vecs[k].lat;
            mem[vecs[k].start_pc] = vecs[k].word;
            exp_addr.push_back(vecs[k].start_pc);
            exp_data.push_back(vecs[k].word);
            bus.instr_ready = 1'b0;
            jump_idle(vecs[k].start_pc);
            bus.halt = 1'b0;
            tick();
            chk("vec_req", {31'h0, bus.mem_req}, 32'h1);
            chk("vec_addr", {24'h0, bus.mem_addr}, {24'h0, vecs[k].start_pc});
            bus.halt = 1'b1;
            wait_valid();
            chk("vec_data", {12'h0, bus.instr_data}, {12'h0, vecs[k].word});
            chk("vec_pc", {24'h0, bus.pc}, {24'h0, vecs[k].exp_pc});
            bus.instr_ready = 1'b1;
            tick();
            chk("vec_drop", {31'h0, bus.instr_valid}, 32'h0);
            tick();
            chk("vec_halted", {31'h0, bus.mem_req}, 32'h0);
            drain();
        end

        // PC wrapped from 0xFF: next request must go to 0x00.
        lat_cfg = 0;
        exp_addr.push_back(8'h00); exp_data.push_back(mem[8'h00]);
        bus.halt = 1'b0;
        tick();
        chk("wrap_req", {31'h0, bus.mem_req}, 32'h1);
        chk("wrap_addr", {24'h0, bus.mem_addr}, 32'h0);
        bus.halt = 1'b1;
        drain();

        // Jump while WAIT: the reply is discarded and the target is fetched next.
        jump_idle(8'h30);
        lat_cfg = 3;
        exp_addr.push_back(8'h30);
        exp_addr.push_back(8'h40); exp_data.push_back(mem[8'h40]);
        bus.halt = 1'b0;
        tick();
        bus.jump_en   = 1'b1;
        bus.jump_addr = 8'h40;
        tick();
        bus.jump_en = 1'b0;
        chk("flush_pc", {24'h0, bus.pc}, 32'h40);
        chk("flush_req_held", {31'h0, bus.mem_req}, 32'h1);
        begin
            int n = 0;
            while (bus.mem_req && n < 20) begin
                tick();
                n++;
                chk("flush_no_valid", {31'h0, bus.instr_valid}, 32'h0);
            end
        end
        chk("flush_req_done", {31'h0, bus.mem_req}, 32'h0);
        tick();
        chk("flush_next_req", {31'h0, bus.mem_req}, 32'h1);
        chk("flush_next_addr", {24'h0, bus.mem_addr}, 32'h40);
        chk("flush_pc_kept", {24'h0, bus.pc}, 32'h40);
        bus.halt = 1'b1;
        drain();

        // Jump together with ready on a held word: dropped, not accepted.
        lat_cfg = 0;
        bus.instr_ready = 1'b0;
        jump_idle(8'h50);
        exp_addr.push_back(8'h50);
        bus.halt = 1'b0;
        tick();
        bus.halt = 1'b1;
        wait_valid();
        bus.instr_ready = 1'b1;
        bus.jump_en     = 1'b1;
        bus.jump_addr   = 8'h60;
        tick();
        bus.jump_en     = 1'b0;
        bus.instr_ready = 1'b0;
        chk("hold_jump_valid", {31'h0, bus.instr_valid}, 32'h0);
        chk("hold_jump_pc", {24'h0, bus.pc}, 32'h60);
        exp_addr.push_back(8'h60); exp_data.push_back(mem[8'h60]);
        bus.halt = 1'b0;
        tick();
        chk("hold_jump_req", {31'h0, bus.mem_req}, 32'h1);
        chk("hold_jump_addr", {24'h0, bus.mem_addr}, 32'h60);
        bus.halt = 1'b1;
        bus.instr_ready = 1'b1;
        drain();

        // Halt in IDLE keeps the bus quiet.
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("halt_idle_req", {31'h0, bus.mem_req}, 32'h0);
        end
        chk("addr_queue_empty", exp_addr.size(), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
